// File: rtl/sorted_array_serializer.sv
// -----------------------------------------------------------------------------
// sorted_array_serializer
//
// Captures one N-element signed array (normally the sorter's output bus) under
// a valid/ready handshake, then streams the elements out one per cycle, index 0
// first, on a valid/ready stream with a last marker. While capturing, it also
// checks that the frame is in the expected order. The verdict is flagged on
// order_err_o for every beat of that frame; the check never alters the data.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its payload stable
// until that edge. ready_o depends only on state and ready_i, never on valid_i.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   array_i      in   N x W signed frame, element 0 first
//   valid_i      in   array_i holds a frame to capture
//   ready_o      out  a frame can be captured this cycle
//   data_o       out  current element (0 when idle)
//   valid_o      out  data_o/index_o/last_o/order_err_o are valid
//   ready_i      in   downstream accepts the current element
//   last_o       out  current element is index N-1
//   index_o      out  index of the current element
//   order_err_o  out  captured frame violated the DESCEND order
//   state_o      out  debug: FSM state (0 = IDLE, 1 = SEND)
// -----------------------------------------------------------------------------
module sorted_array_serializer #(
   parameter int N       = 8,
   parameter int W       = 32,
   parameter bit DESCEND = 1'b0,
   localparam int IDX_W  = $clog2(N)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic signed [W-1:0] array_i [N],
   input  logic                valid_i,
   output logic                ready_o,
   output logic signed [W-1:0] data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                last_o,
   output logic [IDX_W-1:0]    index_o,
   output logic                order_err_o,
   output logic                state_o
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_index;
   logic [IDX_W-1:0]    w_index_nxt;
   logic signed [W-1:0] r_mem [N];
   logic                r_err;
   logic                w_capture;
   logic                w_last;
   logic                w_order_err;

   assign w_last = (r_state == SEND) && (r_index == IDX_W'(N - 1));

   // Adjacent-pair signed comparison over the incoming frame; equal
   // neighbours are legal in either direction.
   always_comb begin
      w_order_err = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         if (DESCEND) begin
            if (array_i[i] < array_i[i+1]) w_order_err = 1'b1;
         end else begin
            if (array_i[i] > array_i[i+1]) w_order_err = 1'b1;
         end
      end
   end

   // Next-state and capture decision. The last accepted beat may capture a
   // new frame in the same cycle, which keeps back-to-back frames bubble-free.
   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid_i) begin
               w_capture   = 1'b1;
               w_state_nxt = SEND;
               w_index_nxt = '0;
            end
         end
         SEND: begin
            if (ready_i) begin
               if (w_last) begin
                  w_index_nxt = '0;
                  if (valid_i) begin
                     w_capture   = 1'b1;
                     w_state_nxt = SEND;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_index_nxt = r_index + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_index_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_index <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
         if (w_capture) r_err <= w_order_err;
      end
   end

   // Frame storage needs no reset: it is only read while in SEND, which is
   // reachable only through a capture.
   always_ff @(posedge clk_i) begin
      if (w_capture) begin
         for (int i = 0; i < N; i++) r_mem[i] <= array_i[i];
      end
   end

   assign valid_o     = (r_state == SEND);
   assign ready_o     = (r_state == IDLE) || (ready_i && w_last);
   assign last_o      = w_last;
   assign index_o     = r_index;
   assign data_o      = valid_o ? r_mem[r_index] : '0;
   assign order_err_o = valid_o & r_err;
   assign state_o     = r_state;

endmodule

// File: tb/tb_sorted_array_serializer.sv
// -----------------------------------------------------------------------------
// Bench for sorted_array_serializer. Two instances share clock, reset, array
// and ready: u_dut_a checks non-decreasing order, u_dut_d non-increasing.
// `sel` picks which instance receives valid and is observed.
// -----------------------------------------------------------------------------
module tb_sorted_array_serializer;

   localparam int N = 8;
   localparam int W = 32;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus
   logic signed [W-1:0] arr_drv [N];
   logic                vld = 1'b0;
   logic                rdy = 1'b0;
   logic                sel = 1'b0;

   // per-instance outputs
   logic                ready_a, valid_a, last_a, err_a, st_a;
   logic                ready_d, valid_d, last_d, err_d, st_d;
   logic signed [W-1:0] data_a, data_d;
   logic [2:0]          idx_a, idx_d;

   sorted_array_serializer #(.N(N), .W(W), .DESCEND(1'b0)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .array_i(arr_drv), .valid_i(vld & ~sel),
      .ready_o(ready_a), .data_o(data_a), .valid_o(valid_a), .ready_i(rdy),
      .last_o(last_a), .index_o(idx_a), .order_err_o(err_a), .state_o(st_a)
   );

   sorted_array_serializer #(.N(N), .W(W), .DESCEND(1'b1)) u_dut_d (
      .clk_i(clk), .rst_ni(rst_n), .array_i(arr_drv), .valid_i(vld & sel),
      .ready_o(ready_d), .data_o(data_d), .valid_o(valid_d), .ready_i(rdy),
      .last_o(last_d), .index_o(idx_d), .order_err_o(err_d), .state_o(st_d)
   );

   logic                m_ready, m_valid, m_last, m_err;
   logic signed [W-1:0] m_data;
   logic [2:0]          m_idx;
   assign m_ready = sel ? ready_d : ready_a;
   assign m_valid = sel ? valid_d : valid_a;
   assign m_last  = sel ? last_d  : last_a;
   assign m_err   = sel ? err_d   : err_a;
   assign m_data  = sel ? data_d  : data_a;
   assign m_idx   = sel ? idx_d   : idx_a;

   // scoreboard
   logic [W-1:0] exp_q[$];
   logic         cur_err;
   int           checks = 0;
   int           errors = 0;

   // directed frames
   logic signed [W-1:0] f_sorted   [N] = '{-345345, 0, 0, 1, 8, 325, 325, 325};
   logic signed [W-1:0] f_unsorted [N] = '{325, 0, -345345, 1, 325, 0, 325, 8};
   logic signed [W-1:0] f_signed_up[N] = '{-1, 1, 2, 3, 4, 5, 6, 7};
   logic signed [W-1:0] f_signed_dn[N] = '{1, -1, -2, -3, -4, -5, -6, -7};

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Present a frame at the next negedge; it is captured on the following
   // posedge. The next driver call drops valid at its own negedge.
   task automatic capture(input logic signed [W-1:0] arr [N], input logic exp_err);
      @(negedge clk);
      arr_drv = arr;
      vld     = 1'b1;
      rdy     = 1'b1;
      #1;
      check("cap_ready", {31'b0, m_ready}, 1);
      for (int i = 0; i < N; i++) exp_q.push_back(arr[i]);
      cur_err = exp_err;
   endtask

   // One element: optional stall cycles with ready low, then acceptance.
   // keep_vld leaves valid high so a last beat captures the frame the caller
   // already placed on arr_drv.
   task automatic do_beat(input int idx, input int stall, input logic keep_vld);
      logic [W-1:0] e;
      @(negedge clk);
      vld = keep_vld;
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
         return;
      end
      e = exp_q[0];
      for (int s = 0; s < stall; s++) begin
         rdy = 1'b0;
         #1;
         check("stall_valid", {31'b0, m_valid}, 1);
         check("stall_data",  m_data, e);
         check("stall_index", {29'b0, m_idx}, idx);
         check("stall_ready", {31'b0, m_ready}, 0);
         @(negedge clk);
      end
      rdy = 1'b1;
      #1;
      check("beat_valid", {31'b0, m_valid}, 1);
      check("beat_data",  m_data, e);
      check("beat_index", {29'b0, m_idx}, idx);
      check("beat_last",  {31'b0, m_last}, (idx == N - 1) ? 1 : 0);
      check("beat_err",   {31'b0, m_err}, {31'b0, cur_err});
      check("beat_ready", {31'b0, m_ready}, (idx == N - 1) ? 1 : 0);
      void'(exp_q.pop_front());
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      vld = 1'b0;
      #1;
      check({tag, "_valid"}, {31'b0, m_valid}, 0);
      check({tag, "_ready"}, {31'b0, m_ready}, 1);
      check({tag, "_data"},  m_data, 0);
      check({tag, "_index"}, {29'b0, m_idx}, 0);
      check({tag, "_last"},  {31'b0, m_last}, 0);
      check({tag, "_err"},   {31'b0, m_err}, 0);
   endtask

   task automatic run_frame(input logic signed [W-1:0] arr [N], input logic exp_err,
                            input int stall_i1, input int stall_i2);
      capture(arr, exp_err);
      for (int i = 0; i < N; i++)
         do_beat(i, (i == stall_i1 || i == stall_i2) ? 3 : 0, 1'b0);
      idle_check("post");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      cur_err = 1'b0;
      for (int i = 0; i < N; i++) arr_drv[i] = '0;

      // reset held for 3 cycles, then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_check("reset");
      idle_check("idle");

      // sorted frame with duplicates, no backpressure
      run_frame(f_sorted, 1'b0, -1, -1);
      // same frame, 3-cycle stalls on beats 2 and 5
      run_frame(f_sorted, 1'b0, 1, 4);
      // unsorted frame passes unchanged with error flagged
      run_frame(f_unsorted, 1'b1, -1, -1);
      // signed compare: ascending across zero is ordered
      run_frame(f_signed_up, 1'b0, -1, -1);

      // DESCEND=1 instance
      sel = 1'b1;
      idle_check("d_idle");
      run_frame(f_signed_dn, 1'b0, -1, -1);
      run_frame(f_signed_up, 1'b1, -1, -1);
      sel = 1'b0;

      // back-to-back: sorted frame then unsorted frame with no bubble
      capture(f_sorted, 1'b0);
      for (int i = 0; i < N - 1; i++) do_beat(i, 0, 1'b0);
      @(posedge clk);
      arr_drv = f_unsorted;
      do_beat(N - 1, 0, 1'b1);
      for (int i = 0; i < N; i++) exp_q.push_back(f_unsorted[i]);
      cur_err = 1'b1;
      do_beat(0, 0, 1'b0);
      do_beat(1, 0, 1'b0);

      // reset pulse at beat 3 of the second frame aborts it immediately
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_valid", {31'b0, m_valid}, 0);
      check("abort_ready", {31'b0, m_ready}, 1);
      check("abort_err",   {31'b0, m_err}, 0);
      check("abort_index", {29'b0, m_idx}, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) idle_check("after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sorted_array_serializer.md
Name: sorted_array_serializer

Overview:
- Reader for the sorter's output bus: captures one N-element signed array (normally `bitonic_sorter` `array_o`) under a valid/ready handshake.
- Streams the captured elements out one per cycle, index 0 first, on a valid/ready stream with `last_o`.
- Checks that the captured frame is in the expected order, flagging errors with `order_err_o`.
- Sits between the combinational sorter and downstream serial consumers (FIFO, UART/AXI-stream bridge).

Parameters:
- N, 8, number of array elements; power of two, ≥2.
- W, 32, element width in bits; elements are signed two's complement.
- DESCEND, 0, expected order: 0 = non-decreasing, 1 = non-increasing; used only by the order checker.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- array_i  input  N x W signed  unpacked array, element 0 first.
- valid_i  input  1  array_i holds a frame to capture.
- ready_o  output  1  block can capture a frame this cycle.
- data_o  output  W signed  current element.
- valid_o  output  1  data_o, index_o, last_o, order_err_o are valid.
- ready_i  input  1  downstream accepts the current element.
- last_o  output  1  current element is index N-1.
- index_o  output  $clog2(N)  index of current element.
- order_err_o  output  1  captured frame violated the DESCEND order; constant across the frame.

Behaviour:
- Reset (async assert, sync-deasserted by the system) clears the state and outputs:
  - FSM goes to IDLE.
  - valid_o=0, data_o=0, index_o=0, last_o=0, order_err_o=0.
  - Capture register contents are don't-care.
- Reset asserted mid-frame aborts the frame; remaining elements are dropped and never emitted.
- FSM states: IDLE, SEND.
- IDLE:
  - ready_o=1.
  - On valid_i: latch array_i into the N x W register, latch the order check result, set index=0, go to SEND.
- SEND:
  - valid_o=1.
  - data_o = reg[index].
  - last_o = (index==N-1).
- SEND, beat accepted (ready_i=1) with index<N-1: index increments.
- SEND, beat accepted on the last element:
  - If valid_i=1 in the same cycle, capture the new frame and stay in SEND with index=0 (back-to-back, no bubble).
  - Otherwise go to IDLE.
- ready_o:
  - 1 in IDLE.
  - 1 in SEND only when valid_o & ready_i & last_o.
  - Otherwise 0.
  - Purely combinational from state and ready_i; no path from valid_i.
- Latency: frame captured in cycle t → element 0 presented at cycle t+1. Best-case frame throughput is N cycles per frame.
- Backpressure: while valid_o=1 and ready_i=0, data_o, index_o, last_o and order_err_o hold stable. valid_o never drops before acceptance.
- array_i and valid_i are ignored when ready_o=0. The upstream must hold them until the handshake completes.
- Order check:
  - Combinational over array_i at capture; signed comparison of every adjacent pair.
  - Error if any a[i] > a[i+1] (DESCEND=0), or any a[i] < a[i+1] (DESCEND=1).
  - Equal neighbours are legal.
  - The result is registered at capture and driven on order_err_o for every beat of that frame.
  - The check never blocks or alters the data stream.
- Index arithmetic is $clog2(N) bits wide; it never wraps past N-1 because the last beat transitions state.

Test Plan:
- Reset/idle: hold rst_ni=0 for 3 cycles, release, no valid_i → valid_o=0, ready_o=1, outputs 0.
- Sorted frame with duplicates, ready_i=1, DESCEND=0: array {-345345,0,0,1,8,325,325,325} → beats 1..8 emit those values in order, index 0..7, last_o only on the 8th beat, order_err_o=0 throughout, ready_o=1 again on the last beat.
- Backpressure: same frame, ready_i=0 on beats 2 and 5 for 3 cycles each → data_o and index_o held; exactly 8 accepted beats in order.
- Unsorted frame {325,0,-345345,1,325,0,325,8} → emitted unchanged; order_err_o=1 on all 8 beats.
- Signed-compare case {-1,1,…}: ordered under DESCEND=0 (no error). With DESCEND=1, {1,-1,-2,…} → no error and {-1,1,…} → error.
- Back-to-back then abort:
  - Two frames, with valid_i held through the first frame's last beat → second frame's element 0 follows in the next cycle with no bubble.
  - Pulse rst_ni low at beat 3 of the second frame → valid_o drops immediately and the block returns to IDLE.
